// File: rtl/temp_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : temp_pkg
// Purpose  : Shared widths, divider length and scan FSM encoding for the
//            temperature scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package temp_pkg;
   localparam int DIV_CYCLES = 16;
   localparam int SUM_W      = 16;
   localparam int CNT_W      = 8;

   typedef logic [2:0] temp_scan_state_t;

   localparam temp_scan_state_t ST_IDLE   = 3'd0;
   localparam temp_scan_state_t ST_SELECT = 3'd1;
   localparam temp_scan_state_t ST_REQ    = 3'd2;
   localparam temp_scan_state_t ST_DIVIDE = 3'd3;
   localparam temp_scan_state_t ST_DONE   = 3'd4;
endpackage
`default_nettype wire

// File: rtl/temp_scan_ctrl_serial_div.sv
`default_nettype none
// ============================================================================
// Module   : temp_serial_div
// Purpose  : Fixed-length restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module temp_serial_div
   import temp_pkg::*;
#(
   parameter int DVD_W = SUM_W,
   parameter int DSR_W = CNT_W,
   parameter int QUO_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [DVD_W-1:0] dividend_i,
   input  logic [DSR_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [QUO_W-1:0] quotient_o
);
   localparam int                STEP_W      = $clog2(DIV_CYCLES);
   localparam logic [STEP_W-1:0] c_step_last = STEP_W'(DIV_CYCLES - 1);

   logic              busy_q, busy_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [DVD_W-1:0]  dvd_q, dvd_d;
   logic [DSR_W-1:0]  dsr_q, dsr_d;
   logic [DSR_W-1:0]  rem_q, rem_d;
   logic [DSR_W:0]    trial;
   logic [DSR_W:0]    diff;
   logic              fits;
   logic [DVD_W-1:0]  dvd_next;

   // Quotient bits shift into the dividend register as dividend bits shift out.
   always_comb begin
      trial    = {rem_q, dvd_q[DVD_W-1]};
      diff     = trial - {1'b0, dsr_q};
      fits     = ~diff[DSR_W];
      dvd_next = {dvd_q[DVD_W-2:0], fits};

      busy_d = busy_q;
      step_d = step_q;
      dvd_d  = dvd_q;
      dsr_d  = dsr_q;
      rem_d  = rem_q;
      if (start_i && !busy_q) begin
         busy_d = 1'b1;
         step_d = '0;
         dvd_d  = dividend_i;
         dsr_d  = divisor_i;
         rem_d  = '0;
      end else if (busy_q) begin
         dvd_d  = dvd_next;
         rem_d  = fits ? diff[DSR_W-1:0] : trial[DSR_W-1:0];
         step_d = step_q + 1'b1;
         if (step_q == c_step_last) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         step_q <= '0;
         dvd_q  <= '0;
         dsr_q  <= '0;
         rem_q  <= '0;
      end else begin
         busy_q <= busy_d;
         step_q <= step_d;
         dvd_q  <= dvd_d;
         dsr_q  <= dsr_d;
         rem_q  <= rem_d;
      end
   end

   // Result is presented together with done, in the final iteration cycle.
   assign busy_o     = busy_q;
   assign done_o     = busy_q && (step_q == c_step_last);
   assign quotient_o = dvd_next[QUO_W-1:0];
endmodule
`default_nettype wire

// File: rtl/temp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : temp_scan_ctrl
// Purpose  : Sequential sensor scan over a shared read bus; sum, count, average.
// Revision : 1.0 - initial release
// ============================================================================
module temp_scan_ctrl
   import temp_pkg::*;
#(
   parameter int WIDTH   = 5,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [WIDTH-1:0]  sensors_en_i,
   output logic              rd_req_o,
   output logic [7:0]        rd_idx_o,
   input  logic              rd_ack_i,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [SUM_W-1:0]  temp_sum_o,
   output logic [CNT_W-1:0]  nr_active_sensors_o,
   output logic [DATA_W-1:0] temp_avg_o,
   output logic [WIDTH-1:0]  err_mask_o
);
   localparam logic [7:0] c_last_idx = 8'(WIDTH);
   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

   temp_scan_state_t  state_q, state_d;
   logic [WIDTH-1:0]  en_q, en_d;
   logic [WIDTH-1:0]  err_q, err_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        timer_q, timer_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SUM_W-1:0]  sum_out_q, sum_out_d;
   logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
   logic [DATA_W-1:0] avg_out_q, avg_out_d;
   logic [WIDTH-1:0]  err_out_q, err_out_d;

   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [DATA_W-1:0] div_quo;
   logic              cur_en;

   // Shift keeps the select in range even when idx has reached WIDTH.
   assign cur_en = |(en_q & (WIDTH'(1) << idx_q));

   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      err_d     = err_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      sum_out_d = sum_out_q;
      cnt_out_d = cnt_out_q;
      avg_out_d = avg_out_q;
      err_out_d = err_out_q;
      div_start = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               en_d    = sensors_en_i;
               err_d   = '0;
               idx_d   = '0;
               timer_d = '0;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (idx_q == c_last_idx) begin
               if (cnt_q != '0) begin
                  div_start = 1'b1;
                  state_d   = ST_DIVIDE;
               end else begin
                  sum_out_d = sum_q;
                  cnt_out_d = cnt_q;
                  avg_out_d = '0;
                  err_out_d = err_q;
                  state_d   = ST_DONE;
               end
            end else if (cur_en) begin
               timer_d = '0;
               state_d = ST_REQ;
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         ST_REQ: begin
            // An ack in the last allowed cycle takes priority over the timeout.
            if (rd_ack_i) begin
               sum_d   = sum_q + SUM_W'(rd_data_i);
               cnt_d   = cnt_q + 1'b1;
               idx_d   = idx_q + 8'd1;
               state_d = ST_SELECT;
            end else if (timer_q == c_tmo_last) begin
               err_d   = err_q | (WIDTH'(1) << idx_q);
               idx_d   = idx_q + 8'd1;
               state_d = ST_SELECT;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_DIVIDE: begin
            if (div_done || !div_busy) begin
               sum_out_d = sum_q;
               cnt_out_d = cnt_q;
               avg_out_d = div_quo;
               err_out_d = err_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         en_q      <= '0;
         err_q     <= '0;
         idx_q     <= '0;
         timer_q   <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         sum_out_q <= '0;
         cnt_out_q <= '0;
         avg_out_q <= '0;
         err_out_q <= '0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         sum_out_q <= sum_out_d;
         cnt_out_q <= cnt_out_d;
         avg_out_q <= avg_out_d;
         err_out_q <= err_out_d;
      end
   end

   temp_serial_div #(
      .DVD_W (SUM_W),
      .DSR_W (CNT_W),
      .QUO_W (DATA_W)
   ) u_div (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (div_start),
      .dividend_i (sum_q),
      .divisor_i  (cnt_q),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   assign rd_req_o            = (state_q == ST_REQ);
   assign rd_idx_o            = (state_q == ST_REQ) ? idx_q : 8'd0;
   assign busy_o              = (state_q != ST_IDLE);
   assign done_o              = (state_q == ST_DONE);
   assign temp_sum_o          = sum_out_q;
   assign nr_active_sensors_o = cnt_out_q;
   assign temp_avg_o          = avg_out_q;
   assign err_mask_o          = err_out_q;
endmodule
`default_nettype wire
